fifo_frame_reader: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 22 ++
 rtl/fifo_frame_reader_if.sv | 31 +++
 rtl/fifo_frame_reader_out_reg.sv | 44 ++++
 rtl/fifo_frame_reader.sv | 122 ++++++++++++
 tb/tb_fifo_frame_reader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the read side of the prefetch FIFO: state encoding,
// default widths and a small counter-sizing helper.
package fifo_rd_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_LEN_WIDTH  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // Bits needed to hold the values 0..maxval, never less than one.
   function automatic int ctr_width(input int maxval);
      int w;
      w = $clog2(maxval + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fifo_frame_reader_if.sv
// Handshake bundles of the frame reader: the show-ahead FIFO read port and the
// framed valid/ready output stream.
interface fifo_rd_if
   import fifo_rd_pkg::*;
   #(parameter int DATA_WIDTH = FIFO_DATA_WIDTH);

   logic                  fifo_rd_en;
   logic                  fifo_rd_vld;
   logic [DATA_WIDTH-1:0] fifo_rd_data;

   modport master (output fifo_rd_en, input fifo_rd_vld, input fifo_rd_data);
   modport slave  (input fifo_rd_en, output fifo_rd_vld, output fifo_rd_data);

endinterface

interface frame_stream_if
   import fifo_rd_pkg::*;
   #(parameter int DATA_WIDTH = FIFO_DATA_WIDTH);

   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_vld;
   logic                  out_rdy;
   logic                  out_sof;
   logic                  out_eof;

   modport master (output out_data, output out_vld, output out_sof, output out_eof,
                   input out_rdy);
   modport slave  (input out_data, input out_vld, input out_sof, input out_eof,
                   output out_rdy);

endinterface

// File: rtl/fifo_frame_reader_out_reg.sv
// Single-entry output holding register for a framed valid/ready stream; the
// source may only load it when it is empty or being drained this cycle.
module frame_out_reg
   import fifo_rd_pkg::*;
   #(parameter int DATA_WIDTH = FIFO_DATA_WIDTH)
   (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  sof_i,
   input  logic                  eof_i,
   frame_stream_if.master        st
   );

   logic [DATA_WIDTH-1:0] data_q;
   logic                  vld_q;
   logic                  sof_q;
   logic                  eof_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= 1'b0;
         sof_q  <= 1'b0;
         eof_q  <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         vld_q  <= 1'b1;
         sof_q  <= sof_i;
         eof_q  <= eof_i;
      end else if (vld_q && st.out_rdy) begin
         vld_q  <= 1'b0;
         sof_q  <= 1'b0;
         eof_q  <= 1'b0;
      end
   end

   assign st.out_data = data_q;
   assign st.out_vld  = vld_q;
   assign st.out_sof  = sof_q;
   assign st.out_eof  = eof_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side consumer of the show-ahead FIFO: pops one frame per start request
// into a framed output stream, drains the FIFO on flush, aborts on starvation.
module fifo_frame_reader
   import fifo_rd_pkg::*;
   #(
   parameter int DATA_WIDTH     = FIFO_DATA_WIDTH,
   parameter int LEN_WIDTH      = FIFO_LEN_WIDTH,
   parameter int TIMEOUT_CYCLES = 4096
   )
   (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 start,
   input  logic                 flush,
   input  logic [LEN_WIDTH-1:0] frame_len,
   fifo_rd_if.master            fifo,
   frame_stream_if.master       st,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err
   );

   localparam int             TW     = ctr_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]  T_MAX  = TW'(TIMEOUT_CYCLES);

   state_t               state_q;
   logic [LEN_WIDTH-1:0] remaining_q;
   logic [TW-1:0]        starve_q;
   logic                 first_q;
   logic                 abort_q;
   logic                 done_q;
   logic                 terr_q;

   logic can_take;
   logic pop;
   logic drop;
   logic eof_d;

   assign can_take = ~st.out_vld | st.out_rdy;
   assign pop      = fifo.fifo_rd_vld & (state_q == ST_RUN) & (remaining_q != '0) & can_take;
   assign drop     = fifo.fifo_rd_vld & (state_q == ST_FLUSH);
   assign eof_d    = (remaining_q == LEN_WIDTH'(1));

   assign fifo.fifo_rd_en = pop | drop;

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         starve_q    <= '0;
         first_q     <= 1'b0;
         abort_q     <= 1'b0;
         done_q      <= 1'b0;
         terr_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         terr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // start takes priority over a simultaneous flush
               if (start) begin
                  if (frame_len != '0) begin
                     remaining_q <= frame_len;
                     starve_q    <= '0;
                     first_q     <= 1'b1;
                     abort_q     <= 1'b0;
                     state_q     <= ST_RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end else if (flush) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_RUN: begin
               if (pop) begin
                  remaining_q <= remaining_q - LEN_WIDTH'(1);
                  first_q     <= 1'b0;
                  starve_q    <= '0;
                  if (eof_d) state_q <= ST_DRAIN;
               end else if (starve_q == T_LAST) begin
                  starve_q <= T_MAX;
                  abort_q  <= 1'b1;
                  state_q  <= ST_DRAIN;
               end else begin
                  starve_q <= starve_q + TW'(1);
               end
            end
            ST_DRAIN: begin
               if (can_take) begin
                  state_q <= ST_IDLE;
                  if (abort_q) terr_q <= 1'b1;
                  else         done_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (!fifo.fifo_rd_vld) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   frame_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
      .clk    (rd_clk),
      .rst    (rd_rst),
      .load_i (pop),
      .data_i (fifo.fifo_rd_data),
      .sof_i  (first_q),
      .eof_i  (eof_d),
      .st     (st)
   );

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: behavioural show-ahead FIFO in front,
// negedge monitor behind, immediate assertions at each check point.
module tb_fifo_frame_reader;

   localparam int DW = 8;
   localparam int LW = 10;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic          busy, done, terr;
   logic          rdy = 1'b1;
   logic          fifo_clr = 1'b0;

   fifo_rd_if      #(.DATA_WIDTH(DW)) fif ();
   frame_stream_if #(.DATA_WIDTH(DW)) sif ();

   fifo_frame_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
      .rd_clk      (clk),
      .rd_rst      (rst),
      .start       (start),
      .flush       (flush),
      .frame_len   (frame_len),
      .fifo        (fif),
      .st          (sif),
      .busy        (busy),
      .done        (done),
      .timeout_err (terr)
   );

   always #5 clk = ~clk;

   // show-ahead FIFO model
   logic [DW-1:0] mem [0:63];
   int            wr_ptr = 0;
   int            rd_ptr = 0;

   assign fif.fifo_rd_vld  = (wr_ptr != rd_ptr);
   assign fif.fifo_rd_data = mem[rd_ptr % 64];
   assign sif.out_rdy      = rdy;

   always @(posedge clk) begin
      if (fifo_clr)            rd_ptr <= wr_ptr;
      else if (fif.fifo_rd_en) rd_ptr <= rd_ptr + 1;
   end

   // monitor
   int            cyc = 0, pops = 0, cap_n = 0, done_cnt = 0, terr_cnt = 0, vld_cnt = 0;
   int            en_err = 0, hold_err = 0, last_pop_cyc = 0, done_cyc = 0, terr_cyc = 0;
   logic [DW-1:0] cap_data [0:255];
   logic          cap_sof  [0:255];
   logic          cap_eof  [0:255];
   int            cap_cyc  [0:255];
   logic          hold_p = 1'b0;
   logic [DW+1:0] held = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (fif.fifo_rd_en) begin
            pops         <= pops + 1;
            last_pop_cyc <= cyc;
         end
         if ((fif.fifo_rd_en && !fif.fifo_rd_vld) ||
             (fif.fifo_rd_en && sif.out_vld && !sif.out_rdy))
            en_err <= en_err + 1;
         if (sif.out_vld) vld_cnt <= vld_cnt + 1;
         if (hold_p && (!sif.out_vld || {sif.out_data, sif.out_sof, sif.out_eof} != held))
            hold_err <= hold_err + 1;
         hold_p <= sif.out_vld && !sif.out_rdy;
         held   <= {sif.out_data, sif.out_sof, sif.out_eof};
         if (sif.out_vld && sif.out_rdy) begin
            cap_data[cap_n] <= sif.out_data;
            cap_sof[cap_n]  <= sif.out_sof;
            cap_eof[cap_n]  <= sif.out_eof;
            cap_cyc[cap_n]  <= cyc;
            cap_n           <= cap_n + 1;
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (terr) begin
            terr_cnt <= terr_cnt + 1;
            terr_cyc <= cyc;
         end
      end else begin
         hold_p <= 1'b0;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] v);
      mem[wr_ptr % 64] = v;
      wr_ptr++;
   endtask

   task automatic pulse_start(input logic [LW-1:0] len);
      frame_len = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // waits for a done or timeout_err pulse; an expired budget is a failed check
   task automatic wait_end(input string tag, input int budget, input bit toggle);
      int d0, t0, n;
      d0 = done_cnt;
      t0 = terr_cnt;
      n  = 0;
      while (done_cnt == d0 && terr_cnt == t0 && n < budget) begin
         if (toggle) rdy = ~rdy;
         tick();
         n++;
      end
      check(tag, 32'(n < budget), 32'd1);
      rdy = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, p0, d0, t0, v0, ns, ne;

      // reset state
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_terr", terr, 0);
      check("rst_vld", sif.out_vld, 0);
      check("rst_sof_eof", {sif.out_sof, sif.out_eof}, 0);
      check("rst_data", sif.out_data, 0);
      check("rst_rd_en", fif.fifo_rd_en, 0);
      rst = 1'b0;
      tick();

      // 8-word frame, always ready
      for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
      c0 = cap_n; p0 = pops; d0 = done_cnt;
      pulse_start(10'd8);
      wait_end("t1_wait", 64, 1'b0);
      check("t1_count", cap_n - c0, 8);
      for (int i = 0; i < 8; i++) check("t1_data", cap_data[c0 + i], 32'h10 + i);
      ns = 0; ne = 0;
      for (int i = 0; i < 8; i++) begin ns += int'(cap_sof[c0 + i]); ne += int'(cap_eof[c0 + i]); end
      check("t1_sof_first", cap_sof[c0], 1);
      check("t1_eof_last", cap_eof[c0 + 7], 1);
      check("t1_sof_eof_cnt", {16'(ns), 16'(ne)}, {16'd1, 16'd1});
      check("t1_pops", pops - p0, 8);
      check("t1_done_cnt", done_cnt - d0, 1);
      check("t1_done_lat", done_cyc - cap_cyc[c0 + 7], 1);
      check("t1_burst", cap_cyc[c0 + 7] - cap_cyc[c0], 7);
      check("t1_busy", busy, 0);

      // same frame with ready toggling 1010...
      for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
      c0 = cap_n; p0 = pops; d0 = done_cnt;
      pulse_start(10'd8);
      wait_end("t2_wait", 128, 1'b1);
      check("t2_count", cap_n - c0, 8);
      for (int i = 0; i < 8; i++) check("t2_data", cap_data[c0 + i], 32'h10 + i);
      check("t2_sof_eof", {cap_sof[c0], cap_eof[c0 + 7], cap_eof[c0 + 6]}, 3'b110);
      check("t2_pops", pops - p0, 8);
      check("t2_done_cnt", done_cnt - d0, 1);
      check("t2_hold", hold_err, 0);
      check("t2_pop_rule", en_err, 0);

      // starvation: 3 words for a 5-word frame. Abort decision on the 16th
      // no-pop cycle, one DRAIN cycle, then the registered pulse: 18 cycles.
      for (int i = 0; i < 3; i++) push(DW'(8'h20 + i));
      c0 = cap_n; p0 = pops; d0 = done_cnt; t0 = terr_cnt;
      pulse_start(10'd5);
      wait_end("t3_wait", 100, 1'b0);
      check("t3_count", cap_n - c0, 3);
      for (int i = 0; i < 3; i++) check("t3_data", cap_data[c0 + i], 32'h20 + i);
      ne = 0;
      for (int i = 0; i < 3; i++) ne += int'(cap_eof[c0 + i]);
      check("t3_no_eof", ne, 0);
      check("t3_sof", cap_sof[c0], 1);
      check("t3_pops", pops - p0, 3);
      check("t3_terr_cnt", terr_cnt - t0, 1);
      check("t3_no_done", done_cnt - d0, 0);
      check("t3_terr_lat", terr_cyc - last_pop_cyc, 18);
      check("t3_busy", busy, 0);

      // flush of 20 words
      for (int i = 0; i < 20; i++) push(DW'(8'h40 + i));
      p0 = pops; d0 = done_cnt; v0 = vld_cnt; t0 = terr_cnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_end("t4_wait", 100, 1'b0);
      check("t4_pops", pops - p0, 20);
      check("t4_no_vld", vld_cnt - v0, 0);
      check("t4_done_cnt", done_cnt - d0, 1);
      check("t4_no_terr", terr_cnt - t0, 0);
      check("t4_empty", fif.fifo_rd_vld, 0);
      check("t4_busy", busy, 0);

      // single-sample frame
      push(8'h5A);
      c0 = cap_n; d0 = done_cnt;
      pulse_start(10'd1);
      wait_end("t5_wait", 32, 1'b0);
      check("t5_count", cap_n - c0, 1);
      check("t5_data", cap_data[c0], 32'h5A);
      check("t5_sof_eof", {cap_sof[c0], cap_eof[c0]}, 2'b11);
      check("t5_done_cnt", done_cnt - d0, 1);

      // zero-length frame: done the cycle after start, no pops
      p0 = pops;
      frame_len = '0;
      start = 1'b1;
      @(negedge clk);
      check("t5z_done_early", done, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("t5z_done", done, 1);
      check("t5z_busy", busy, 0);
      tick();
      check("t5z_pops", pops - p0, 0);

      // start and flush together: start wins
      push(8'h61); push(8'h62);
      c0 = cap_n; d0 = done_cnt;
      frame_len = 10'd2;
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      wait_end("t5s_wait", 32, 1'b0);
      check("t5s_count", cap_n - c0, 2);
      check("t5s_data", {cap_data[c0], cap_data[c0 + 1]}, 16'h6162);
      check("t5s_eof", cap_eof[c0 + 1], 1);
      check("t5s_done_cnt", done_cnt - d0, 1);

      // asynchronous reset mid-frame, then a normal 4-word frame
      for (int i = 0; i < 6; i++) push(DW'(8'h70 + i));
      d0 = done_cnt;
      rdy = 1'b0;
      pulse_start(10'd4);
      repeat (3) tick();
      check("t6_vld_before", {sif.out_vld, busy}, 2'b11);
      check("t6_data_before", sif.out_data, 32'h70);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_vld", sif.out_vld, 0);
      check("t6_rst_data", {sif.out_data, sif.out_sof, sif.out_eof}, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_flags", {fif.fifo_rd_en, done, terr}, 0);
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
      rst = 1'b0;
      rdy = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) push(DW'(8'h30 + i));
      c0 = cap_n;
      pulse_start(10'd4);
      wait_end("t6_wait", 32, 1'b0);
      check("t6_count", cap_n - c0, 4);
      for (int i = 0; i < 4; i++) check("t6_data", cap_data[c0 + i], 32'h30 + i);
      check("t6_sof_eof", {cap_sof[c0], cap_eof[c0 + 3], cap_eof[c0]}, 3'b110);
      check("t6_done_cnt", done_cnt - d0, 1);

      check("end_pop_rule", en_err, 0);
      check("end_hold", hold_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
